// File: rtl/pulse_pkg.sv
// Shared types for the pulse-width decoder: FSM state, symbol classes, counter width.
// PULSE_DECODER_PARITY_EN adds a ninth (even parity) bit to every frame.
package pulse_pkg;

  typedef enum logic {IDLE, DATA} state_e;

  typedef enum logic [1:0] {SYM_GLITCH, SYM_ZERO, SYM_ONE, SYM_SYNC} sym_e;

  localparam int CNT_W = 16;

`ifdef PULSE_DECODER_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  function automatic sym_e classify(input logic [CNT_W-1:0] w,
                                    input logic [CNT_W-1:0] zmin,
                                    input logic [CNT_W-1:0] omin,
                                    input logic [CNT_W-1:0] smin);
    if (w >= smin)      return SYM_SYNC;
    else if (w >= omin) return SYM_ONE;
    else if (w >= zmin) return SYM_ZERO;
    else                return SYM_GLITCH;
  endfunction

endpackage

// File: rtl/pulse_decoder_if.sv
// Byte output handshake of the pulse decoder (valid/ready, one byte per transfer).
interface pulse_decoder_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/pulse_width_meter.sv
// Synchronizes the pulse line, measures level widths and classifies each high pulse
// on its falling edge; also flags a low period that has lasted TIMEOUT cycles.
module pulse_width_meter
  import pulse_pkg::*;
#(
  parameter int ZERO_MIN = 200,
  parameter int ONE_MIN  = 600,
  parameter int SYNC_MIN = 900,
  parameter int TIMEOUT  = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pulse,
  output sym_e o_sym,
  output logic o_sym_vld,
  output logic o_tmo
);

  localparam logic [CNT_W-1:0] ZMIN    = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] OMIN    = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] SMIN    = CNT_W'(SYNC_MIN);
  // Off an edge the line has held its level for r_cnt+2 cycles.
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT - 2);

  logic             r_s1, r_s2, r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge, w_fall;
  logic [CNT_W-1:0] w_width;

  assign w_edge  = r_s2 ^ r_prev;
  assign w_fall  = r_prev & ~r_s2;
  // On the falling-edge cycle the high level lasted r_cnt+1 cycles.
  assign w_width = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      o_sym     <= SYM_GLITCH;
      o_sym_vld <= 1'b0;
      o_tmo     <= 1'b0;
    end else begin
      r_s1   <= i_pulse;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (w_edge)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
      o_sym_vld <= w_fall;
      if (w_fall)
        o_sym <= classify(w_width, ZMIN, OMIN, SMIN);
      o_tmo <= ~r_s2 & ~r_prev & (r_cnt == TMO_CNT);
    end
  end

endmodule

// File: rtl/pulse_decoder.sv
// Pulse-width serial decoder: sync pulse starts a frame, long/short pulses carry
// 1/0 bits LSB first, result lands in a one-entry valid/ready buffer.
// Optional even parity bit with `define PULSE_DECODER_PARITY_EN.
module pulse_decoder
  import pulse_pkg::*;
#(
  parameter int ZERO_MIN = 200,
  parameter int ONE_MIN  = 600,
  parameter int SYNC_MIN = 900,
  parameter int TIMEOUT  = 20000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pulse_in,
  pulse_decoder_if.master out_if,
  output logic            overflow_o,
  output logic            frame_err_o,
  output logic            busy_o
);

  sym_e                  w_sym;
  logic                  w_sym_vld, w_tmo;
  state_e                r_state;
  logic [3:0]            r_bitcnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [7:0]            r_data;
  logic                  r_valid, r_ovf, r_ferr;
  logic                  w_hs, w_bit, w_last, w_par_ok;
  logic [FRAME_BITS-1:0] w_shift_nxt;

  pulse_width_meter #(
    .ZERO_MIN (ZERO_MIN),
    .ONE_MIN  (ONE_MIN),
    .SYNC_MIN (SYNC_MIN),
    .TIMEOUT  (TIMEOUT)
  ) u_meter (
    .clk       (clk),
    .rst       (rst),
    .i_pulse   (pulse_in),
    .o_sym     (w_sym),
    .o_sym_vld (w_sym_vld),
    .o_tmo     (w_tmo)
  );

  assign w_hs        = r_valid & out_if.ready_i;
  assign w_bit       = (w_sym == SYM_ONE);
  assign w_last      = (r_bitcnt == 4'(FRAME_BITS - 1));
  assign w_shift_nxt = {w_bit, r_shift[FRAME_BITS-1:1]};

`ifdef PULSE_DECODER_PARITY_EN
  assign w_par_ok = ~^w_shift_nxt;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
      // A completing frame below may reload the buffer in the same cycle.
      if (w_hs)
        r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sym_vld && w_sym == SYM_SYNC) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
            r_shift  <= '0;
          end
        end
        DATA: begin
          if (w_sym_vld) begin
            case (w_sym)
              SYM_SYNC: begin
                r_bitcnt <= '0;
                r_shift  <= '0;
                r_ferr   <= (r_bitcnt != '0);
              end
              SYM_GLITCH: begin
                r_ferr   <= 1'b1;
                r_state  <= IDLE;
                r_bitcnt <= '0;
              end
              default: begin
                r_shift <= w_shift_nxt;
                if (w_last) begin
                  r_state  <= IDLE;
                  r_bitcnt <= '0;
                  if (!w_par_ok)
                    r_ferr <= 1'b1;
                  else if (!r_valid || w_hs) begin
                    r_data  <= w_shift_nxt[7:0];
                    r_valid <= 1'b1;
                  end else
                    r_ovf <= 1'b1;
                end else
                  r_bitcnt <= r_bitcnt + 4'd1;
              end
            endcase
          end else if (w_tmo) begin
            r_ferr   <= 1'b1;
            r_state  <= IDLE;
            r_bitcnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_if.data_o  = r_data;
  assign out_if.valid_o = r_valid;
  assign overflow_o     = r_ovf;
  assign frame_err_o    = r_ferr;
  assign busy_o         = (r_state == DATA);

endmodule
